// File: rtl/heap_move_long.sv
// Sequential moveLong engine: copies a run of heap elements between array areas one per cycle,
// choosing copy direction for overlap safety, and tracks a per-array length table.
module heap_move_long #(
    parameter  int WIDTH   = 12,
    parameter  int NAREA   = 10,
    parameter  int NARRAYS = 2,
    localparam int AW      = $clog2(NARRAYS * NAREA),
    localparam int IW      = $clog2(NAREA + 1),
    localparam int XW      = (NARRAYS > 1) ? $clog2(NARRAYS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [XW-1:0]    src_array,
    input  logic [IW-1:0]    src_off,
    input  logic [XW-1:0]    tgt_array,
    input  logic [IW-1:0]    tgt_off,
    input  logic [IW-1:0]    len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic             size_clr,
    input  logic [XW-1:0]    size_clr_array,
    input  logic [XW-1:0]    size_q_array,
    output logic [IW-1:0]    size_q_len
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [XW:0] NARR_W  = (XW + 1)'(NARRAYS);
    localparam logic [IW:0] NAREA_W = (IW + 1)'(NAREA);

    state_t        state, state_nxt;
    logic          err_q, desc_q, wr_en_q;
    logic [AW-1:0] rd_ptr, wr_ptr, wr_addr_q;
    logic [IW-1:0] remaining, end_q, tgt_array_q_len;
    logic [XW-1:0] tgt_array_q;
    logic [IW-1:0] len_tbl [NARRAYS];

    // Request decode, evaluated only when a start is accepted in IDLE.
    logic [IW:0]   src_end, tgt_end;
    logic          invalid, desc;
    logic [AW-1:0] src_first, tgt_first;

    assign src_end   = {1'b0, src_off} + {1'b0, len};
    assign tgt_end   = {1'b0, tgt_off} + {1'b0, len};
    assign invalid   = ({1'b0, src_array} >= NARR_W) || ({1'b0, tgt_array} >= NARR_W) ||
                       (src_end > NAREA_W) || (tgt_end > NAREA_W);
    assign desc      = (src_array == tgt_array) && (tgt_off > src_off) && ({1'b0, tgt_off} < src_end);
    assign src_first = AW'(src_array) * AW'(NAREA) + AW'(src_off);
    assign tgt_first = AW'(tgt_array) * AW'(NAREA) + AW'(tgt_off);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (invalid || len == '0) ? DONE : RUN;
            RUN:     if (remaining == IW'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q       <= 1'b0;
            desc_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            wr_addr_q   <= '0;
            remaining   <= '0;
            end_q       <= '0;
            tgt_array_q <= '0;
        end else begin
            wr_en_q <= (state == RUN);
            if (state == IDLE && start) begin
                err_q       <= invalid;
                desc_q      <= desc;
                remaining   <= len;
                end_q       <= tgt_end[IW-1:0];
                tgt_array_q <= tgt_array;
                rd_ptr      <= desc ? src_first + AW'(len) - AW'(1) : src_first;
                wr_ptr      <= desc ? tgt_first + AW'(len) - AW'(1) : tgt_first;
            end else if (state == RUN) begin
                wr_addr_q <= wr_ptr;
                remaining <= remaining - IW'(1);
                rd_ptr    <= desc_q ? rd_ptr - AW'(1) : rd_ptr + AW'(1);
                wr_ptr    <= desc_q ? wr_ptr - AW'(1) : wr_ptr + AW'(1);
            end
        end
    end

    // NOTE: the length table is small architectural state and must read 0 after reset, so it is reset.
    always_ff @(posedge clock) begin
        for (int a = 0; a < NARRAYS; a++) begin
            if (reset)
                len_tbl[a] <= '0;
            else if (size_clr && size_clr_array == XW'(a))
                len_tbl[a] <= '0;
            else if (state == DRAIN && tgt_array_q == XW'(a) && end_q > len_tbl[a])
                len_tbl[a] <= end_q;
        end
    end

    assign tgt_array_q_len = len_tbl[tgt_array_q];
    assign size_q_len = ({1'b0, size_q_array} < NARR_W) ? len_tbl[size_q_array] : '0;

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        error       = (state == DONE) && err_q;
        mem_rd_en   = (state == RUN);
        mem_rd_addr = (state == RUN) ? rd_ptr : '0;
        mem_wr_en   = wr_en_q;
        mem_wr_addr = wr_en_q ? wr_addr_q : '0;
        mem_wr_data = wr_en_q ? mem_rd_data : '0;
    end

    // Kept visible for debug probes; the value itself drives nothing.
    logic unused_ok;
    assign unused_ok = ^tgt_array_q_len;

endmodule

// File: tb/tb_heap_move_long.sv
// Directed bench for heap_move_long: a 1-cycle-latency heap model plus hand-computed per-cycle expectations.
module tb_heap_move_long;

    localparam int WIDTH = 12;
    localparam int AW    = 5;
    localparam int IW    = 4;
    localparam int XW    = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [XW-1:0]    src_array = '0, tgt_array = '0;
    logic [IW-1:0]    src_off = '0, tgt_off = '0, len = '0;
    logic             busy, done, error;
    logic             mem_rd_en, mem_wr_en;
    logic [AW-1:0]    mem_rd_addr, mem_wr_addr;
    logic [WIDTH-1:0] mem_rd_data, mem_wr_data;
    logic             size_clr = 1'b0;
    logic [XW-1:0]    size_clr_array = '0, size_q_array = '0;
    logic [IW-1:0]    size_q_len;

    heap_move_long dut (
        .clock(clock), .reset(reset), .start(start),
        .src_array(src_array), .src_off(src_off), .tgt_array(tgt_array), .tgt_off(tgt_off), .len(len),
        .busy(busy), .done(done), .error(error),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .size_clr(size_clr), .size_clr_array(size_clr_array),
        .size_q_array(size_q_array), .size_q_len(size_q_len)
    );

    always #5 clock = ~clock;

    // Heap model with one-cycle read latency.
    logic [WIDTH-1:0] heap [20];
    int wr_count = 0;
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= heap[mem_rd_addr];
        if (mem_wr_en) begin
            heap[mem_wr_addr] = mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int w0;
    int exp_ov [10] = '{0, 1, 2, 3, 2, 3, 4, 5, 6, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic init_heap();
        for (int i = 0; i < 10; i++) begin
            heap[i]      = WIDTH'(i);
            heap[10 + i] = WIDTH'(100 + i);
        end
    endtask

    // Called at a negedge of an idle cycle (cycle 0); returns at the negedge of cycle 1.
    task automatic do_start(input int sa, input int so, input int ta, input int to, input int l);
        src_array = XW'(sa); src_off = IW'(so);
        tgt_array = XW'(ta); tgt_off = IW'(to); len = IW'(l);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int max_cyc);
        while (!done && cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
        end
        if (!done) check("done_timeout", {31'b0, done}, 1);
    endtask

    task automatic get_len(input int arr, output int val);
        size_q_array = XW'(arr);
        #1;
        val = int'(size_q_len);
    endtask

    int lv;

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        init_heap();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_error", {31'b0, error}, 0);
        check("rst_rd_en", {31'b0, mem_rd_en}, 0);
        check("rst_wr_en", {31'b0, mem_wr_en}, 0);
        check("rst_rd_addr", {27'b0, mem_rd_addr}, 0);
        get_len(0, lv); check("rst_len0", lv, 0);
        get_len(1, lv); check("rst_len1", lv, 0);

        // Basic move src(0,4) -> tgt(1,2), len 3
        do_start(0, 4, 1, 2, 3);
        check("b_c1_rd_en", {31'b0, mem_rd_en}, 1);
        check("b_c1_rd_addr", {27'b0, mem_rd_addr}, 4);
        check("b_c1_wr_en", {31'b0, mem_wr_en}, 0);
        check("b_c1_busy", {31'b0, busy}, 1);
        @(negedge clock);
        check("b_c2_rd_addr", {27'b0, mem_rd_addr}, 5);
        check("b_c2_wr_en", {31'b0, mem_wr_en}, 1);
        check("b_c2_wr_addr", {27'b0, mem_wr_addr}, 12);
        check("b_c2_wr_data", {20'b0, mem_wr_data}, 4);
        @(negedge clock);
        check("b_c3_wr_addr", {27'b0, mem_wr_addr}, 13);
        check("b_c3_wr_data", {20'b0, mem_wr_data}, 5);
        @(negedge clock);
        check("b_c4_rd_en", {31'b0, mem_rd_en}, 0);
        check("b_c4_wr_addr", {27'b0, mem_wr_addr}, 14);
        check("b_c4_wr_data", {20'b0, mem_wr_data}, 6);
        @(negedge clock);
        check("b_c5_done", {31'b0, done}, 1);
        check("b_c5_error", {31'b0, error}, 0);
        check("b_c5_wr_en", {31'b0, mem_wr_en}, 0);
        get_len(1, lv); check("b_len1", lv, 5);
        get_len(0, lv); check("b_len0", lv, 0);
        @(negedge clock);
        check("b_c6_busy", {31'b0, busy}, 0);
        check("b_c6_done", {31'b0, done}, 0);
        check("b_heap12", {20'b0, heap[12]}, 4);
        check("b_heap13", {20'b0, heap[13]}, 5);
        check("b_heap14", {20'b0, heap[14]}, 6);
        check("b_heap11", {20'b0, heap[11]}, 101);
        check("b_heap15", {20'b0, heap[15]}, 105);

        // Overlapping move inside array 0, descending
        do_start(0, 2, 0, 4, 5);
        check("ov_c1_rd_addr", {27'b0, mem_rd_addr}, 6);
        @(negedge clock); cyc++;
        check("ov_c2_rd_addr", {27'b0, mem_rd_addr}, 5);
        check("ov_c2_wr_addr", {27'b0, mem_wr_addr}, 8);
        check("ov_c2_wr_data", {20'b0, mem_wr_data}, 6);
        wait_done(20);
        check("ov_done_cycle", cyc, 7);
        get_len(0, lv); check("ov_len0", lv, 9);
        @(negedge clock);
        for (int i = 0; i < 10; i++) check($sformatf("ov_heap%0d", i), {20'b0, heap[i]}, exp_ov[i]);

        // Invalid: source run past the area end
        w0 = wr_count;
        do_start(0, 7, 1, 0, 4);
        check("inv_done", {31'b0, done}, 1);
        check("inv_error", {31'b0, error}, 1);
        check("inv_busy", {31'b0, busy}, 1);
        check("inv_rd_en", {31'b0, mem_rd_en}, 0);
        @(negedge clock);
        check("inv_c2_busy", {31'b0, busy}, 0);
        repeat (3) @(negedge clock);
        check("inv_no_writes", wr_count, w0);
        get_len(0, lv); check("inv_len0", lv, 9);
        get_len(1, lv); check("inv_len1", lv, 5);

        // Invalid: target run past the area end
        do_start(0, 0, 1, 8, 3);
        check("inv_tgt_error", {31'b0, error}, 1);
        @(negedge clock);

        // Exact boundary src_off+len == NAREA is valid
        do_start(0, 6, 1, 0, 4);
        wait_done(20);
        check("bnd_done_cycle", cyc, 6);
        check("bnd_error", {31'b0, error}, 0);
        get_len(1, lv); check("bnd_len1", lv, 5);
        @(negedge clock);

        // Zero length
        w0 = wr_count;
        do_start(0, 3, 1, 9, 0);
        check("z_done", {31'b0, done}, 1);
        check("z_error", {31'b0, error}, 0);
        check("z_rd_en", {31'b0, mem_rd_en}, 0);
        @(negedge clock);
        check("z_no_writes", wr_count, w0);
        get_len(1, lv); check("z_len1", lv, 5);

        // Length never shrinks
        do_start(0, 0, 1, 5, 3);
        wait_done(20);
        get_len(1, lv); check("grow_len1", lv, 8);
        @(negedge clock);
        do_start(0, 0, 1, 0, 3);
        wait_done(20);
        get_len(1, lv); check("noshrink_len1", lv, 8);
        @(negedge clock);

        // Clear on the update edge wins
        do_start(0, 0, 1, 0, 3);
        repeat (3) @(negedge clock);
        size_clr = 1'b1; size_clr_array = 1'b1;
        @(negedge clock);
        size_clr = 1'b0;
        check("clr_done", {31'b0, done}, 1);
        get_len(1, lv); check("clr_len1", lv, 0);
        get_len(0, lv); check("clr_len0", lv, 9);
        @(negedge clock);

        // Start while busy is ignored
        do_start(0, 0, 1, 0, 4);
        @(negedge clock); cyc++;
        src_off = 4'd7; start = 1'b1;
        @(negedge clock); cyc++;
        start = 1'b0;
        check("busy_rd_addr", {27'b0, mem_rd_addr}, 2);
        wait_done(20);
        check("busy_done_cycle", cyc, 6);
        check("busy_error", {31'b0, error}, 0);
        get_len(1, lv); check("busy_len1", lv, 4);
        // Start during the done cycle is ignored
        src_array = 1'b0; src_off = 4'd0; tgt_array = 1'b1; tgt_off = 4'd0; len = 4'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("done_start_ignored", {31'b0, busy}, 0);
        // Back-to-back: accept in the cycle after done
        do_start(0, 0, 1, 0, 1);
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_rd_en", {31'b0, mem_rd_en}, 1);
        check("b2b_rd_addr", {27'b0, mem_rd_addr}, 0);
        wait_done(20);
        check("b2b_done_cycle", cyc, 3);
        @(negedge clock);

        // Reset in cycle 3 of a len=6 move
        for (int i = 0; i < 10; i++) heap[10 + i] = WIDTH'(100 + i);
        w0 = wr_count;
        do_start(0, 0, 1, 0, 6);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mr_busy", {31'b0, busy}, 0);
        check("mr_done", {31'b0, done}, 0);
        check("mr_error", {31'b0, error}, 0);
        check("mr_rd_en", {31'b0, mem_rd_en}, 0);
        check("mr_wr_en", {31'b0, mem_wr_en}, 0);
        check("mr_rd_addr", {27'b0, mem_rd_addr}, 0);
        check("mr_wr_addr", {27'b0, mem_wr_addr}, 0);
        check("mr_wr_data", {20'b0, mem_wr_data}, 0);
        get_len(0, lv); check("mr_len0", lv, 0);
        get_len(1, lv); check("mr_len1", lv, 0);
        repeat (5) @(negedge clock);
        check("mr_write_count", wr_count, w0 + 2);
        check("mr_heap10", {20'b0, heap[10]}, 0);
        check("mr_heap11", {20'b0, heap[11]}, 1);
        check("mr_heap12", {20'b0, heap[12]}, 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
